// File: rtl/fifo_umbrales_pkg.sv
// Shared widths, threshold bundle layout and operation decode for the threshold FIFO.
package fifo_umbrales_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 6;
  localparam int unsigned ADDR_WIDTH_DEF = 2;
  localparam int unsigned UMBRAL_WIDTH   = ADDR_WIDTH_DEF;

  // Threshold pair as packed into the FSM umbrales_I bundle.
  typedef struct packed {
    logic [UMBRAL_WIDTH-1:0] umbral_alto;
    logic [UMBRAL_WIDTH-1:0] umbral_bajo;
  } umbrales_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e op_decode(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_umbrales_if.sv
// Push/pop, threshold and status bundle of the threshold FIFO.
interface fifo_umbrales_if
  import fifo_umbrales_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  wr_enable;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] umbral_alto;
  logic [ADDR_WIDTH-1:0] umbral_bajo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  modport master (
    output wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo,
    input  data_out, valid_out, fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo,
    output data_out, valid_out, fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );

endinterface

// File: rtl/fifo_umbrales_memoria_fifo.sv
// Dual-port register array: synchronous write, registered read.
module memoria_fifo
  import fifo_umbrales_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Same-edge write and read of one address returns the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with almost-full/almost-empty thresholds and a sticky error flag.
module fifo_umbrales
  import fifo_umbrales_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  fifo_umbrales_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  error_q, error_d;
  logic                  valid_q;
  logic                  full, empty;
  logic                  push_ok, pop_ok;

  assign full  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign pop_ok  = bus.rd_enable & ~empty;
  assign push_ok = bus.wr_enable & (~full | pop_ok);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (op_decode(push_ok, pop_ok))
      OP_PUSH: begin
        count_d  = count_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      OP_POP: begin
        count_d  = count_q - 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
    // Overflow is a push refused while full; underflow is any pop while empty.
    error_d = error_q
            | (bus.wr_enable & full & ~pop_ok)
            | (bus.rd_enable & empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      error_q  <= error_d;
      valid_q  <= pop_ok;
    end
  end

  memoria_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_memoria_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.data_in),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (bus.data_out)
  );

  assign bus.valid_out    = valid_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count_q >= {1'b0, bus.umbral_alto});
  assign bus.almost_empty = (count_q <= {1'b0, bus.umbral_bajo});
  assign bus.fifo_error   = error_q;

endmodule
